rx_parity: RTL and testbench

//  Receive-side parity checker for the USRT receiver. Takes the 11-bit frame

---
 rtl/usrt_pkg.sv | 30 +++
 rtl/parity_gen.sv | 19 +
 rtl/rx_parity.sv | 62 ++++++
 tb/tb_rx_parity.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: frame layout, parity modes and field indices used by the RX and TX paths.
package usrt_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FRAME_W  = DATA_W + 3;
    localparam int unsigned PAR_BIT  = 8;
    localparam int unsigned STOP_BIT = 9;
    localparam int unsigned RSVD_BIT = 10;

    // Mode 2'b11 is a second encoding of "no parity".
    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } par_mode_t;

    // Field order matches the shift-register capture: payload in the low bits.
    typedef struct packed {
        logic              rsvd;
        logic              stop;
        logic              par;
        logic [DATA_W-1:0] data;
    } rx_frame_t;

    function automatic logic par_check_en(input par_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/parity_gen.sv
// Expected parity bit for a payload under the selected mode; shared between RX check and TX generation.
module parity_gen
    import usrt_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    output logic              par_bit_c
);

    always_comb begin
        par_bit_c = 1'b0;
        case (par_mode_t'(mode))
            PAR_EVEN: par_bit_c = ^data;
            PAR_ODD:  par_bit_c = ~(^data);
            default:  par_bit_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/rx_parity.sv
// Receive-side parity checker: strips the captured frame to its payload and registers a parity verdict.
// Optional stop-bit check enabled by defining RXPARITY_FRAME_CHECK_EN (adds o_FrameErr).
module rx_parity
    import usrt_pkg::*;
(
    input  logic               i_Pclk,
    input  logic               i_Rst,
    input  logic [1:0]         i_Parity,
    input  logic [FRAME_W-1:0] i_Data,
    output logic [DATA_W-1:0]  o_Data,
    output logic               o_ParityOK
`ifdef RXPARITY_FRAME_CHECK_EN
    ,
    output logic               o_FrameErr
`endif
);

    rx_frame_t frame_c;
    par_mode_t mode_c;
    logic      par_exp_c;
    logic      par_ok_c;

    assign frame_c = rx_frame_t'(i_Data);
    assign mode_c  = par_mode_t'(i_Parity);

    parity_gen u_parity_gen (
        .data      (frame_c.data),
        .mode      (i_Parity),
        .par_bit_c (par_exp_c)
    );

    // Modes without parity always report good; the received parity bit is don't-care there.
    assign par_ok_c = ~par_check_en(mode_c) | (frame_c.par == par_exp_c);

    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            o_Data     <= '0;
            o_ParityOK <= 1'b0;
        end else begin
            o_Data     <= frame_c.data;
            o_ParityOK <= par_ok_c;
        end
    end

`ifdef RXPARITY_FRAME_CHECK_EN
    // Stop bit must be 1; verdict is independent of the parity mode.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            o_FrameErr <= 1'b0;
        end else begin
            o_FrameErr <= ~frame_c.stop;
        end
    end

    logic unused_bits_c;
    assign unused_bits_c = frame_c.rsvd;
`else
    logic unused_bits_c;
    assign unused_bits_c = &{1'b0, frame_c.rsvd, frame_c.stop};
`endif

endmodule

// File: tb/tb_rx_parity.sv
// Scoreboard bench for rx_parity: directed frames plus randomized traffic against a behavioural model.
module tb_rx_parity;
    import usrt_pkg::*;

    logic               i_Pclk = 1'b0;
    logic               i_Rst = 1'b1;
    logic [1:0]         i_Parity = 2'b00;
    logic [FRAME_W-1:0] i_Data = '0;
    logic [DATA_W-1:0]  o_Data;
    logic               o_ParityOK;
    logic               o_FrameErr_s;

    rx_parity dut (
        .i_Pclk     (i_Pclk),
        .i_Rst      (i_Rst),
        .i_Parity   (i_Parity),
        .i_Data     (i_Data),
        .o_Data     (o_Data),
`ifdef RXPARITY_FRAME_CHECK_EN
        .o_ParityOK (o_ParityOK),
        .o_FrameErr (o_FrameErr_s)
`else
        .o_ParityOK (o_ParityOK)
`endif
    );

`ifndef RXPARITY_FRAME_CHECK_EN
    assign o_FrameErr_s = 1'b0;
`endif

    always #5 i_Pclk = ~i_Pclk;

    typedef struct {
        int unsigned due;
        string       name;
        logic [7:0]  data;
        logic        ok;
        logic        ferr;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge i_Pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: parity counted directly from the number of ones in payload+parity bit.
    task automatic drive(input logic rst, input logic [1:0] mode, input logic [10:0] frame,
                         input string name);
        exp_t e;
        int   ones;
        @(posedge i_Pclk);
        #1;
        i_Rst    = rst;
        i_Parity = mode;
        i_Data   = frame;
        ones     = $countones(frame[8:0]);
        e.due    = cyc + 1;
        e.name   = name;
        if (rst) begin
            e.data = 8'h00;
            e.ok   = 1'b0;
            e.ferr = 1'b0;
        end else begin
            e.data = frame[7:0];
            if (mode == 2'b01)      e.ok = ((ones % 2) == 0);
            else if (mode == 2'b10) e.ok = ((ones % 2) == 1);
            else                    e.ok = 1'b1;
`ifdef RXPARITY_FRAME_CHECK_EN
            e.ferr = (frame[9] == 1'b0);
`else
            e.ferr = 1'b0;
`endif
        end
        sbq.push_back(e);
    endtask

    // Monitor: outputs must match exactly one cycle after the sampling edge.
    always @(negedge i_Pclk) begin : monitor
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL %s: response missed, due cycle %0d now %0d", e.name, e.due, cyc);
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk({e.name, ".data"}, o_Data, e.data);
            chk({e.name, ".parok"}, {7'd0, o_ParityOK}, {7'd0, e.ok});
`ifdef RXPARITY_FRAME_CHECK_EN
            chk({e.name, ".frameerr"}, {7'd0, o_FrameErr_s}, {7'd0, e.ferr});
`endif
        end
    end

    initial begin
        logic [10:0] f;
        logic [1:0]  m;
        logic        r;

        drive(1'b1, 2'b01, 11'h7FF, "reset0");
        drive(1'b1, 2'b10, 11'h7FF, "reset1");

        drive(1'b0, 2'b01, 11'b000_0000_0111, "even_07");
        drive(1'b0, 2'b10, 11'b000_0000_0111, "odd_07");
        drive(1'b0, 2'b01, 11'b000_0000_1111, "even_0f");
        drive(1'b0, 2'b10, 11'b000_0000_1111, "odd_0f");
        drive(1'b0, 2'b00, 11'b001_0000_0001, "none00_101");
        drive(1'b0, 2'b11, 11'b001_0000_0001, "none11_101");
        drive(1'b0, 2'b01, 11'b010_0000_0000, "stop_hi");
        drive(1'b0, 2'b01, 11'b000_0000_0000, "stop_lo");
        drive(1'b0, 2'b10, 11'b100_0000_0000, "rsvd_only");
        drive(1'b0, 2'b01, 11'h7FF, "all_ones_even");
        drive(1'b1, 2'b01, 11'h2A5, "reset_mid");
        drive(1'b0, 2'b10, 11'h6FF, "odd_ff_p0");

        for (int i = 0; i < 400; i++) begin
            f = 11'($urandom);
            m = 2'($urandom);
            r = ($urandom_range(0, 19) == 0);
            drive(r, m, f, "rand");
            // Mid-cycle glitch on the inputs must not reach the outputs.
            if ($urandom_range(0, 3) == 0) begin
                #1;
                i_Data   = 11'($urandom);
                i_Parity = 2'($urandom);
                #1;
                i_Data   = f;
                i_Parity = m;
            end
        end

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge i_Pclk);
        @(negedge i_Pclk);
        #1;
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
